// File: rtl/avalon_tile_pkg.sv
// rtl/avalon_tile_pkg.sv - shared beat/word widths and unpacker state encoding
package avalon_tile_pkg;

  localparam int DW   = 32;
  localparam int XDW  = 128;
  localparam int WCNT = XDW / DW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UNPACK = 2'd2,
    ST_DONE   = 2'd3
  } unpack_state_e;

endpackage

// File: rtl/rmst_data_unpacker.sv
// rtl/rmst_data_unpacker.sv - splits read-master beats into DW words for the load FIFO
// Optional macro UNPACK_STALL_CNT_EN adds the stall_cnt back-pressure counter output.
module rmst_data_unpacker #(
  parameter int AW  = 12,
  parameter int DW  = avalon_tile_pkg::DW,
  parameter int XDW = avalon_tile_pkg::XDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_data_start,
  input  logic [AW-1:0]  param_iolen,
  input  logic           rmst_user_data_available,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  output logic           rmst_user_read_buffer,
  input  logic           load_fifo_almost_full,
  output logic           load_fifo_push,
  output logic [DW-1:0]  rmst_load_data,
  output logic           load_data_done,
  output logic           busy
`ifdef UNPACK_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  import avalon_tile_pkg::*;

  localparam int LANES = XDW / DW;
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  unpack_state_e  state_q, state_d;
  logic [AW-1:0]  rem_q, rem_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [XDW-1:0] hold_q, hold_d;
  logic           push_q, push_d;
  logic [DW-1:0]  data_q, data_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    push_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (load_data_start) begin
          rem_d   = param_iolen;
          state_d = (param_iolen != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (rmst_user_data_available) begin
          hold_d  = rmst_user_buffer_data;
          idx_d   = '0;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        // Back-pressure freezes the whole datapath; only a free FIFO advances a lane.
        if (!load_fifo_almost_full) begin
          push_d = 1'b1;
          data_d = hold_q[idx_q*DW +: DW];
          rem_d  = rem_q - 1'b1;
          idx_d  = idx_q + 1'b1;
          if (rem_q == AW'(1)) begin
            state_d = ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  assign rmst_user_read_buffer = (state_q == ST_FETCH) && rmst_user_data_available;
  assign load_fifo_push        = push_q;
  assign rmst_load_data        = data_q;
  assign load_data_done        = (state_q == ST_DONE);
  assign busy                  = (state_q != ST_IDLE);

`ifdef UNPACK_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && load_data_start) begin
      stall_d = '0;
    end else if ((state_q == ST_UNPACK) && load_fifo_almost_full && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rmst_data_unpacker.sv
// tb/tb_rmst_data_unpacker.sv - randomized self-checking bench for rmst_data_unpacker
// Honours UNPACK_STALL_CNT_EN to also check the stall counter.
module tb_rmst_data_unpacker;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int XDW = 128;
  localparam int W   = XDW / DW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  iolen = '0;
  logic           avail = 1'b0;
  logic [XDW-1:0] bdata = '0;
  logic           rd;
  logic           af = 1'b0;
  logic           push;
  logic [DW-1:0]  ldata;
  logic           done;
  logic           busy;
`ifdef UNPACK_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  rmst_data_unpacker #(.AW(AW), .DW(DW), .XDW(XDW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .load_data_start          (start),
    .param_iolen              (iolen),
    .rmst_user_data_available (avail),
    .rmst_user_buffer_data    (bdata),
    .rmst_user_read_buffer    (rd),
    .load_fifo_almost_full    (af),
    .load_fifo_push           (push),
    .rmst_load_data           (ldata),
    .load_data_done           (done),
    .busy                     (busy)
`ifdef UNPACK_STALL_CNT_EN
    ,
    .stall_cnt                (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  logic [XDW-1:0] beat_q[$];
  logic [DW-1:0]  exp_q[$];
  int push_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int exp_total = 0;
  bit rand_af = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_src();
    avail = (beat_q.size() > 0);
    bdata = avail ? beat_q[0] : '0;
  endtask

  // Output monitor and random back-pressure source.
  always @(negedge clk) begin
    if (rst) begin
      if (push) begin
        push_cnt++;
        if (exp_q.size() == 0) check("push_overrun", push_cnt, exp_total);
        else check("push_data", ldata, exp_q.pop_front());
      end
      if (done) done_cnt++;
      if (rand_af) af = ($urandom_range(0, 3) == 0);
    end
  end

  // Show-ahead source: the beat is consumed at the edge following the acknowledge.
  always @(negedge clk) begin
    if (rst && rd) begin
      rd_cnt++;
      @(posedge clk);
      #1;
      if (beat_q.size() > 0) beat_q.delete(0);
      refresh_src();
    end
  end

  task automatic prepare(input int n, input bit seq);
    logic [XDW-1:0] beat;
    logic [DW-1:0]  val;
    int nb;
    beat_q.delete();
    exp_q.delete();
    nb = (n + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int k = 0; k < W; k++) begin
        val = seq ? DW'(b * W + k) : DW'($urandom);
        beat[k*DW +: DW] = val;
        if (b * W + k < n) exp_q.push_back(val);
      end
      beat_q.push_back(beat);
    end
    refresh_src();
    push_cnt  = 0;
    rd_cnt    = 0;
    done_cnt  = 0;
    exp_total = n;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk); #2;
    iolen = AW'(n);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("done_seen", (done_cnt > 0), 1);
  endtask

  task automatic finish_checks(input int n, input string tag);
    repeat (3) begin
      @(negedge clk); #2;
    end
    check({tag, "_pushes"}, push_cnt, n);
    check({tag, "_reads"}, rd_cnt, (n + W - 1) / W);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_xfer(input int n, input bit seq, input string tag, output int cyc);
    prepare(n, seq);
    pulse_start(n);
    wait_done(cyc);
    finish_checks(n, tag);
  endtask

  initial begin
    int cyc;
    int base;
    int t;
    int n;

    #2 rst = 1'b0;
    prepare(1, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_push", push, 0);
    check("rst_read", rd, 0);
    check("rst_done", done, 0);
    check("rst_data", ldata, 0);
    rst = 1'b1;

    run_xfer(8, 1'b1, "full8", cyc);
    check("full8_cycles", cyc, 2 * (W + 1));

    run_xfer(6, 1'b1, "part6", cyc);

    run_xfer(0, 1'b1, "zero", cyc);
    check("zero_latency", (cyc <= 2), 1);

    // Five-cycle FIFO stall in the middle of the first beat.
    prepare(8, 1'b1);
    pulse_start(8);
    t = 0;
    while (push_cnt < 2 && t < 100) begin
      @(negedge clk); #2;
      t++;
    end
    check("stall_reach", push_cnt, 2);
    base = push_cnt;
    af = 1'b1;
    repeat (5) begin
      @(negedge clk); #2;
    end
    check("stall_no_push", push_cnt, base);
    af = 1'b0;
    wait_done(cyc);
    finish_checks(8, "stall");
`ifdef UNPACK_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 5);
`endif

    // A second start while busy must not disturb the transfer.
    prepare(8, 1'b1);
    pulse_start(8);
    repeat (3) @(negedge clk);
    pulse_start(3);
    check("restart_busy", busy, 1);
    wait_done(cyc);
    finish_checks(8, "restart");

    // Reset in the middle of a transfer, then a clean short one.
    prepare(8, 1'b1);
    pulse_start(8);
    t = 0;
    while (push_cnt < 3 && t < 100) begin
      @(negedge clk); #2;
      t++;
    end
    check("midrst_reach", push_cnt, 3);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_push", push, 0);
    check("midrst_read", rd, 0);
    check("midrst_done", done, 0);
    check("midrst_data", ldata, 0);
    repeat (2) @(negedge clk);
    beat_q.delete();
    exp_q.delete();
    refresh_src();
    #2 rst = 1'b1;
    run_xfer(4, 1'b1, "after_rst", cyc);

    rand_af = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(1, 23);
      run_xfer(n, 1'b0, "rand", cyc);
    end
    rand_af = 1'b0;
    af = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rmst_data_unpacker.md
RMST_DATA_UNPACKER -- requirements
Module: rmst_data_unpacker

Interface
REQ-001 SHALL have parameter AW, default 12, word-count width.
REQ-002 SHALL have parameter DW, default 32, load-FIFO word width.
REQ-003 SHALL have parameter XDW, default 128, read-master beat width; XDW SHALL be an integer multiple of DW, with WCNT = XDW/DW lanes.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port load_data_start, input, 1: one-cycle start pulse.
REQ-007 SHALL have port param_iolen, input, AW: number of DW words to deliver; sampled on start.
REQ-008 SHALL have port rmst_user_data_available, input, 1: read-master buffer non-empty.
REQ-009 SHALL have port rmst_user_buffer_data, input, XDW: show-ahead head beat of the read-master buffer.
REQ-010 SHALL have port rmst_user_read_buffer, output, 1: beat acknowledge/pop.
REQ-011 SHALL have port load_fifo_almost_full, input, 1: downstream FIFO back-pressure.
REQ-012 SHALL have port load_fifo_push, output, 1: FIFO write strobe.
REQ-013 SHALL have port rmst_load_data, output, DW: FIFO write data.
REQ-014 SHALL have port load_data_done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, UNPACK, DONE.
REQ-017 IDLE: on load_data_start SHALL latch param_iolen into remaining counter; next state FETCH if iolen>0, else DONE.
REQ-018 FETCH: rmst_user_read_buffer SHALL equal (state==FETCH && data_available) combinationally; in that cycle the beat SHALL be captured into a holding register, lane index cleared to 0, next state UNPACK.
REQ-019 UNPACK: each cycle with load_fifo_almost_full low SHALL emit lane[idx] (lane 0 = bits DW-1:0 first), decrement remaining, increment idx; with almost_full high SHALL hold all state.
REQ-020 After an emit, if remaining reaches 0, next state DONE; else if idx was WCNT-1, next state FETCH; otherwise stay in UNPACK.
REQ-021 A partial final beat SHALL discard its unused upper lanes; exactly param_iolen words SHALL be pushed.
REQ-022 load_fifo_push and rmst_load_data SHALL be registered: one-cycle latency from the emit decision; push SHALL be low in every cycle with no emit.
REQ-023 DONE: load_data_done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 load_data_start while busy SHALL be ignored, with no effect on counters.
REQ-025 Throughput SHALL be WCNT words per WCNT+1 cycles with no back-pressure.

Reset
REQ-026 Asserting rst (low) at any time, including mid-transfer, SHALL force IDLE, clear counters, holding register and idx, and drive busy, push, read_buffer and done to 0 and rmst_load_data to 0; partial data SHALL be dropped.

Configuration
REQ-027 Macro UNPACK_STALL_CNT_EN SHALL, when defined, add output stall_cnt, 16 bits: count of UNPACK cycles with almost_full high, saturating at 0xFFFF, cleared on accepted start and reset; when undefined, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 DW, XDW, WCNT and the FSM state encoding SHALL live in shared package avalon_tile_pkg.
REQ-029 The block SHALL be flat; no sub-module is required.

Verification
REQ-030 Bench SHALL drive iolen=8 with two beats 0x00000003_00000002_00000001_00000000 and 0x...7_6_5_4 and no back-pressure -> pushes 0..7 in order, 2 read_buffer pulses, a single done pulse.
REQ-031 Bench SHALL drive iolen=6 -> 6 pushes (0..5), lanes 6 and 7 discarded, 2 read_buffer pulses, done.
REQ-032 Bench SHALL drive iolen=0 -> done within 2 cycles of start, with 0 pushes and 0 read_buffer.
REQ-033 Bench SHALL hold almost_full high for 5 cycles mid-beat -> no push in that window, data order preserved, and stall_cnt=5 when UNPACK_STALL_CNT_EN is defined.
REQ-034 Bench SHALL pulse start again while busy -> ignored; total pushes equal the first iolen.
REQ-035 Bench SHALL assert rst after 3 pushes of iolen=8 -> all outputs 0 and state IDLE; a new start with iolen=4 SHALL complete normally.
